bin_to_bcd_responder: RTL and testbench

- Responder side of the sensor block's binary-to-BCD handshake.
- Accepts a 16-bit binary distance with a request strobe.
- Converts it to packed BCD digits by sequential double-dabble, one bit per clock.
- Returns the digits with a held completion flag; runs on the same slow clock the sensor block exports for BCD work.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bin_to_bcd_responder_if.sv | 39 +++
 rtl/bcd_digit_adj.sv | 7 +
 rtl/bin_to_bcd_responder.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_responder.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD responder.
// Optional ASCII output is enabled with BCD_ASCII_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_responder_if.sv
// Request/response bundle between the sensor block (master) and the BCD responder (slave).
// ascii_out exists only when BCD_ASCII_EN is defined.
interface bin_to_bcd_responder_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) ();
  import bcd_pkg::*;

  // data_in_vld is a level request sampled only in IDLE; bcd_rcvd rises when
  // the result is ready and stays high until the next request is captured.
  // A request must drop data_in_vld before another capture can happen.
  logic [BIN_WIDTH-1:0] data_in;
  logic                 data_in_vld;
  logic [4*DIGITS-1:0]  bcd_out;
  logic                 bcd_rcvd;
  logic                 busy;
  logic                 ovf;
  state_t               state;
`ifdef BCD_ASCII_EN
  logic [8*DIGITS-1:0]  ascii_out;
`endif

  modport master (
    output data_in, data_in_vld,
    input  bcd_out, bcd_rcvd, busy, ovf, state
`ifdef BCD_ASCII_EN
    , input ascii_out
`endif
  );

  modport slave (
    input  data_in, data_in_vld,
    output bcd_out, bcd_rcvd, busy, ovf, state
`ifdef BCD_ASCII_EN
    , output ascii_out
`endif
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_responder.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_ASCII_EN to add the ascii_out digit bytes.
module bin_to_bcd_responder
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic clk,
  input  logic rst,
  bin_to_bcd_responder_if.slave bus
);

  localparam int AW    = 4 * DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(bcd_max(DIGITS));
  localparam logic [AW-1:0]        SAT     = {DIGITS{4'h9}};

  state_t               state;
  logic [BIN_WIDTH-1:0] sr;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        acc_adj;
  logic [AW-1:0]        result;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_pending;
  logic [AW-1:0]        bcd_q;
  logic                 rcvd_q;
  logic                 busy_q;
  logic                 ovf_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(acc[4*i +: 4]),
      .q(acc_adj[4*i +: 4])
    );
  end

  assign result = ovf_pending ? SAT : acc;

`ifdef BCD_ASCII_EN
  logic [8*DIGITS-1:0] ascii_q;
  logic [8*DIGITS-1:0] ascii_next;

  for (genvar i = 0; i < DIGITS; i++) begin : g_ascii
    assign ascii_next[8*i +: 8] = ASCII_ZERO + {4'h0, result[4*i +: 4]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ascii_q <= '0;
    end else if (state == DONE) begin
      ascii_q <= ascii_next;
    end
  end

  assign bus.ascii_out = ascii_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      sr          <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_q       <= '0;
      rcvd_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_in_vld) begin
            sr          <= bus.data_in;
            acc         <= '0;
            cnt         <= '0;
            rcvd_q      <= 1'b0;
            busy_q      <= 1'b1;
            ovf_pending <= (bus.data_in > MAX_VAL);
            state       <= CONV;
          end
        end
        CONV: begin
          // Correct then shift {acc, sr} left by one as a single wide register.
          acc <= (acc_adj << 1) | AW'(sr[BIN_WIDTH-1]);
          sr  <= sr << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          // Outputs rewrite identical values while parked here waiting for vld low.
          bcd_q  <= result;
          ovf_q  <= ovf_pending;
          rcvd_q <= 1'b1;
          busy_q <= 1'b0;
          if (!bus.data_in_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.bcd_rcvd = rcvd_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_bin_to_bcd_responder.sv
// Self-checking bench for bin_to_bcd_responder: directed cases plus random values
// against a decimal-arithmetic reference. Honors BCD_ASCII_EN.
module tb_bin_to_bcd_responder;

  localparam int BW = 16;
  localparam int ND = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [4*ND-1:0] exp_q[$];

  bin_to_bcd_responder_if #(.BIN_WIDTH(BW), .DIGITS(ND)) ifc ();

  bin_to_bcd_responder #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturated to all nines above 9999.
  function automatic logic [4*ND-1:0] ref_bcd(input int unsigned v);
    logic [4*ND-1:0] r;
    int unsigned p;
    r = '0;
    if (v > 9999) return {ND{4'h9}};
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

`ifdef BCD_ASCII_EN
  function automatic logic [8*ND-1:0] ref_ascii(input logic [4*ND-1:0] b);
    logic [8*ND-1:0] a;
    for (int i = 0; i < ND; i++) a[8*i +: 8] = 8'h30 + {4'h0, b[4*i +: 4]};
    return a;
  endfunction
`endif

  // Issue one request; vld stays high for 'hold' edges after the capture edge.
  task automatic do_req(input logic [BW-1:0] v, input int hold);
    logic [4*ND-1:0] exp_bcd;
    int   lat;
    int   rises;
    bit   got;
    logic prev_busy;
    exp_q.push_back(ref_bcd(v));
    @(negedge clk);
    ifc.data_in     = v;
    ifc.data_in_vld = 1'b1;
    @(posedge clk); #1;
    check("cap_rcvd", 32'(ifc.bcd_rcvd), 32'd0);
    check("cap_busy", 32'(ifc.busy), 32'd1);
    if (hold == 0) ifc.data_in_vld = 1'b0;
    lat = 0; got = 0; rises = 0; prev_busy = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) ifc.data_in = (v == 16'd7) ? 16'hFFFF : 16'd7;
      if (ifc.busy && !prev_busy) rises++;
      prev_busy = ifc.busy;
      if (ifc.bcd_rcvd) got = 1;
      if (lat >= hold) ifc.data_in_vld = 1'b0;
    end
    check("latency", got ? 32'(lat) : 32'hFFFF_FFFF, 32'd17);
    exp_bcd = exp_q.pop_front();
    check("bcd_out", 32'(ifc.bcd_out), 32'(exp_bcd));
    check("ovf", 32'(ifc.ovf), (v > 16'd9999) ? 32'd1 : 32'd0);
    check("done_busy", 32'(ifc.busy), 32'd0);
`ifdef BCD_ASCII_EN
    check("ascii", 32'(ifc.ascii_out), 32'(ref_ascii(exp_bcd)));
`endif
    while (lat < hold) begin
      @(posedge clk); #1;
      lat++;
      if (ifc.busy && !prev_busy) rises++;
      prev_busy = ifc.busy;
    end
    ifc.data_in_vld = 1'b0;
    if (hold > 17) begin
      check("no_retrigger", 32'(rises), 32'd0);
      check("held_bcd", 32'(ifc.bcd_out), 32'(exp_bcd));
    end
    @(posedge clk); #1;
    check("rcvd_hold", 32'(ifc.bcd_rcvd), 32'd1);
  endtask

  initial begin
    logic [BW-1:0] rv;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ifc.data_in     = '0;
    ifc.data_in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", 32'(ifc.bcd_out), 32'd0);
    check("rst_rcvd", 32'(ifc.bcd_rcvd), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_ovf", 32'(ifc.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_req(16'd0, 0);
    do_req(16'd1234, 0);
    do_req(16'd9999, 0);
    do_req(16'd10000, 0);
    do_req(16'd42, 40);

    // Reset in the middle of a conversion.
    @(negedge clk);
    ifc.data_in = 16'd777;
    ifc.data_in_vld = 1'b1;
    @(posedge clk); #1;
    ifc.data_in_vld = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    check("mid_rst_rcvd", 32'(ifc.bcd_rcvd), 32'd0);
    check("mid_rst_bcd", 32'(ifc.bcd_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req(16'd305, 0);

    // Sensor-style alternating requests.
    do_req(16'd1, 0);
    do_req(16'd58, 0);
    do_req(16'd400, 0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'($urandom_range(9990, 10010));
        1:       rv = 16'($urandom_range(0, 99));
        default: rv = 16'($urandom_range(0, 65535));
      endcase
      do_req(rv, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
